program_loader: RTL and testbench

Byte-stream program loader that fills the CPU core's program memory: the writer side of the instruction-fetch path the control unit reads through `PC`. It accepts a framed byte stream over a valid/ready handshake and packs bytes MSB-first into instruction words. It writes each word to consecutive program-memory addresses starting at 0, and holds the CPU in reset (`cpu_hold`) while a load is in progress. It sits between the host link (UART receiver or test harness) and the program-memory write port.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/word_packer.sv | 38 +++
 rtl/program_loader.sv | 129 ++++++++++++
 tb/tb_program_loader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions used by the program loader and its word packer.
// The loader's optional checksum stage is selected with PROGRAM_LOADER_CHECKSUM_EN.
package cpu_pkg;

  localparam int LOADER_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/word_packer.sv
// Packs stream bytes MSB-first into an instruction word and flags the byte
// that completes it, so the loader can schedule the memory write next cycle.
module word_packer
  import cpu_pkg::*;
#(
  parameter int INSTR_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     shift_en,
  input  logic [LOADER_BYTE_W-1:0] byte_in,
  output logic [INSTR_W-1:0]       word_next,
  output logic                     word_full
);

  localparam int BPW = INSTR_W / LOADER_BYTE_W;
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [INSTR_W-1:0] word_q;
  logic [CW-1:0]      cnt_q;

  assign word_next = (word_q << LOADER_BYTE_W) | INSTR_W'(byte_in);
  assign word_full = shift_en && (cnt_q == CW'(BPW - 1));

  // The counter restarts once a word completes; the register keeps shifting
  // and the loader captures word_next on the completing byte.
  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (shift_en) begin
      word_q <= word_next;
      cnt_q  <= word_full ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader: count byte, N MSB-first words, then (with
// PROGRAM_LOADER_CHECKSUM_EN defined) an XOR checksum byte. Holds the CPU while loading.
module program_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [LOADER_BYTE_W-1:0] rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic                     pm_write,
  output logic [ADDR_W-1:0]        pm_addr,
  output logic [INSTR_W-1:0]       pm_wdata,
  output logic                     cpu_hold,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [ADDR_W:0]          words_loaded
);

  localparam logic [8:0] MAX_WORDS = 9'(1 << ADDR_W);

  loader_state_t      state_q, state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  pm_addr_q;
  logic [INSTR_W-1:0] pm_wdata_q;
  logic [ADDR_W:0]    words_q;
  logic [ADDR_W:0]    count_q;
  logic [INSTR_W-1:0] word_next;
  logic               word_full;
  logic               start_ok;
  logic               count_ok;
  logic               last_word;

  assign start_ok  = start && (state_q inside {IDLE, DONE, ERROR});
  assign count_ok  = (rx_data != '0) && ({1'b0, rx_data} <= MAX_WORDS);
  assign last_word = ((words_q + 1'b1) == count_q);

  assign rx_ready     = (state_q inside {COUNT, DATA, CSUM});
  assign pm_write     = (state_q == WRITE);
  assign busy         = (state_q inside {COUNT, DATA, WRITE, CSUM});
  assign cpu_hold     = busy || (state_q == ERROR);
  assign done         = (state_q == DONE);
  assign error        = (state_q == ERROR);
  assign pm_addr      = pm_addr_q;
  assign pm_wdata     = pm_wdata_q;
  assign words_loaded = words_q;

  word_packer #(.INSTR_W(INSTR_W)) u_packer (
    .clock     (clock),
    .reset     (reset),
    .clear     (start_ok),
    .shift_en  ((state_q == DATA) && rx_valid),
    .byte_in   (rx_data),
    .word_next (word_next),
    .word_full (word_full)
  );

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [LOADER_BYTE_W-1:0] csum_q;

  // Running XOR over the count byte and every data byte of the frame.
  always_ff @(posedge clock) begin
    if (!reset || start_ok) begin
      csum_q <= '0;
    end else if ((state_q inside {COUNT, DATA}) && rx_valid) begin
      csum_q <= csum_q ^ rx_data;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERROR: if (start) state_d = COUNT;
      COUNT: if (rx_valid) state_d = count_ok ? DATA : ERROR;
      DATA:  if (word_full) state_d = WRITE;
      WRITE: begin
        if (last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_d = CSUM;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = DATA;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CSUM:  if (rx_valid) state_d = (rx_data == csum_q) ? DONE : ERROR;
`endif
      default: state_d = IDLE;
    endcase
  end

  // addr_q is the next write address; pm_addr_q/pm_wdata_q present the
  // current write and hold it afterwards.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      pm_addr_q  <= '0;
      pm_wdata_q <= '0;
      words_q    <= '0;
      count_q    <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        addr_q    <= '0;
        pm_addr_q <= '0;
        words_q   <= '0;
      end
      if ((state_q == COUNT) && rx_valid) count_q <= rx_data[ADDR_W:0];
      if (word_full) begin
        pm_addr_q  <= addr_q;
        pm_wdata_q <= word_next;
      end
      if (state_q == WRITE) begin
        addr_q  <= addr_q + 1'b1;
        words_q <= words_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader; expected writes are queued by the
// stimulus and checked by a monitor whenever pm_write is high.
module tb_program_loader;

  localparam int ADDR_W  = 5;
  localparam int INSTR_W = 16;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic                  start = 1'b0;
  logic [7:0]            rx_data = 8'h00;
  logic                  rx_valid = 1'b0;
  logic                  rx_ready;
  logic                  pm_write;
  logic [ADDR_W-1:0]     pm_addr;
  logic [INSTR_W-1:0]    pm_wdata;
  logic                  cpu_hold;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [ADDR_W:0]       words_loaded;

  logic [ADDR_W+INSTR_W-1:0] exp_q[$];
  int                        vectors = 0;
  int                        miscompares = 0;
  logic [7:0]                run_xor = 8'h00;

  program_loader #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .pm_write     (pm_write),
    .pm_addr      (pm_addr),
    .pm_wdata     (pm_wdata),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clock) begin
    if (pm_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                 pm_addr, pm_wdata);
      end else begin
        logic [ADDR_W+INSTR_W-1:0] e;
        e = exp_q.pop_front();
        check_output("write_addr", 32'(pm_addr), 32'(e[ADDR_W+INSTR_W-1:INSTR_W]));
        check_output("write_data", 32'(pm_wdata), 32'(e[INSTR_W-1:0]));
        check_output("rx_ready_in_write", 32'(rx_ready), 32'd0);
      end
    end
  end

  task automatic apply_stimulus(input logic [7:0] b, input int gap);
    int waited = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && waited < 20) begin
      @(posedge clock); #1;
      waited++;
    end
    if (!rx_ready) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL rx_ready_timeout: got 0, expected 1 for byte 0x%0h", b);
    end
    @(posedge clock); #1;
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [ADDR_W-1:0] addr, input logic [15:0] data,
                           input int gap);
    exp_q.push_back({addr, data});
    run_xor = run_xor ^ data[15:8] ^ data[7:0];
    apply_stimulus(data[15:8], gap);
    apply_stimulus(data[7:0], gap);
  endtask

  task automatic send_std_frame(input int gap);
    run_xor = 8'h02;
    apply_stimulus(8'h02, gap);
    send_word(5'd0, 16'h1234, gap);
    send_word(5'd1, 16'hABCD, gap);
  endtask

  task automatic finish_frame();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    apply_stimulus(run_xor, 0);
`else
    @(posedge clock); #1;
`endif
  endtask

  task automatic check_done(input int words);
    check_output("done", 32'(done), 32'd1);
    check_output("error_after_done", 32'(error), 32'd0);
    check_output("busy_after_done", 32'(busy), 32'd0);
    check_output("cpu_hold_after_done", 32'(cpu_hold), 32'd0);
    check_output("words_loaded", 32'(words_loaded), 32'(words));
  endtask

  task automatic check_reset_values();
    check_output("rst_rx_ready", 32'(rx_ready), 32'd0);
    check_output("rst_pm_write", 32'(pm_write), 32'd0);
    check_output("rst_pm_addr", 32'(pm_addr), 32'd0);
    check_output("rst_pm_wdata", 32'(pm_wdata), 32'd0);
    check_output("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_error", 32'(error), 32'd0);
    check_output("rst_words_loaded", 32'(words_loaded), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, expected run to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] bad_counts [2];
    bad_counts[0] = 8'h00;
    bad_counts[1] = 8'h21;

    reset    = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    repeat (2) @(posedge clock);
    #1;
    check_reset_values();
    rx_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clock); #1;

    pulse_start();
    check_output("count_rx_ready", 32'(rx_ready), 32'd1);
    check_output("count_cpu_hold", 32'(cpu_hold), 32'd1);
    check_output("count_busy", 32'(busy), 32'd1);
    send_std_frame(0);
    check_output("last_write_strobe", 32'(pm_write), 32'd1);
    check_output("last_write_cpu_hold", 32'(cpu_hold), 32'd1);
    finish_frame();
    check_done(2);
    check_output("hold_pm_addr", 32'(pm_addr), 32'd1);
    check_output("hold_pm_wdata", 32'(pm_wdata), 32'hABCD);

    foreach (bad_counts[i]) begin
      pulse_start();
      check_output("start_clears_done", 32'(done), 32'd0);
      check_output("start_clears_words", 32'(words_loaded), 32'd0);
      apply_stimulus(bad_counts[i], 0);
      check_output("bad_count_error", 32'(error), 32'd1);
      check_output("bad_count_cpu_hold", 32'(cpu_hold), 32'd1);
      check_output("bad_count_busy", 32'(busy), 32'd0);
      check_output("bad_count_rx_ready", 32'(rx_ready), 32'd0);
    end

    pulse_start();
    check_output("start_clears_error", 32'(error), 32'd0);
    send_std_frame(0);
    finish_frame();
    check_done(2);

    pulse_start();
    send_std_frame(3);
    finish_frame();
    check_done(2);

    pulse_start();
    run_xor = 8'h02;
    apply_stimulus(8'h02, 0);
    send_word(5'd0, 16'h1234, 0);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_values();
    reset = 1'b1;
    @(posedge clock); #1;
    pulse_start();
    send_std_frame(0);
    finish_frame();
    check_done(2);

    pulse_start();
    run_xor = 8'h20;
    apply_stimulus(8'h20, 0);
    for (int i = 0; i < 32; i++) begin
      send_word(5'(i), {8'(i) ^ 8'hC3, 8'(i * 7)}, 0);
    end
    finish_frame();
    check_done(32);
    check_output("max_last_addr", 32'(pm_addr), 32'd31);
    check_output("max_last_data", 32'(pm_wdata), 32'hDCD9);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    pulse_start();
    send_std_frame(0);
    apply_stimulus(8'h43, 0);
    check_output("bad_csum_error", 32'(error), 32'd1);
    check_output("bad_csum_done", 32'(done), 32'd0);
    check_output("bad_csum_cpu_hold", 32'(cpu_hold), 32'd1);
    check_output("bad_csum_words", 32'(words_loaded), 32'd2);
`endif

    repeat (2) @(posedge clock);
    #1;
    check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
